rptr_status: RTL and testbench

RPTR_STATUS -- requirements
Module: rptr_status

---
 rtl/async_fifo_pkg.sv | 38 +++
 rtl/rptr_status_if.sv | 31 +++
 rtl/gray2bin.sv | 14 +
 rtl/rptr_status.sv | 83 ++++++++
 tb/tb_rptr_status.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/async_fifo_pkg.sv
// Shared pointer-conversion helpers for the async FIFO read and write sides.
// Pointers are at most 13 bits wide (ADDRSIZE up to 12, plus one wrap bit).
// Callers pass values zero-extended to ptr_word_t, then size-cast the result
// back to their own pointer width. The width argument masks off any bits
// above the pointer's real width.
package async_fifo_pkg;

  localparam int PTR_MAX_W = 13;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t width_mask(input int width);
    return (ptr_word_t'(1) << width) - ptr_word_t'(1);
  endfunction

  function automatic ptr_word_t bin2gray(input ptr_word_t bin, input int width);
    ptr_word_t b;
    b = bin & width_mask(width);
    return (b >> 1) ^ b;
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  // A running parity from the MSB down yields every bit in one pass.
  function automatic ptr_word_t gray2bin(input ptr_word_t gray, input int width);
    ptr_word_t g;
    ptr_word_t b;
    logic      acc;
    g   = gray & width_mask(width);
    b   = '0;
    acc = 1'b0;
    for (int i = PTR_MAX_W - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

endpackage

// File: rtl/rptr_status_if.sv
// Read-side FIFO status bus.
//   master: drives the synchronised write pointer, read request, threshold
//           load and underflow clear.
//   slave : the read-pointer/status block.
//           It returns empty, almost-empty, level, memory address,
//           the Gray read pointer and the sticky underflow flag.
interface rptr_status_if #(
  parameter int ADDRSIZE = 4
);
  logic [ADDRSIZE:0]   rq2_wptr;
  logic                rinc;
  logic                ae_wr;
  logic [ADDRSIZE:0]   ae_thresh;
  logic                uf_clr;
  logic                rempty;
  logic                ralmost_empty;
  logic [ADDRSIZE:0]   rlevel;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                runderflow;

  modport master (
    output rq2_wptr, rinc, ae_wr, ae_thresh, uf_clr,
    input  rempty, ralmost_empty, rlevel, raddr, rptr, runderflow
  );

  modport slave (
    input  rq2_wptr, rinc, ae_wr, ae_thresh, uf_clr,
    output rempty, ralmost_empty, rlevel, raddr, rptr, runderflow
  );
endinterface

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter of parameterised width.
// Ports:
//   gray : Gray-coded input, WIDTH bits.
//   bin  : binary equivalent, WIDTH bits.
module gray2bin
  import async_fifo_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);
  assign bin = WIDTH'(async_fifo_pkg::gray2bin(ptr_word_t'(gray), WIDTH));
endmodule

// File: rtl/rptr_status.sv
// Read-pointer and status logic for an asynchronous FIFO, in the rclk domain.
// Ports:
//   rclk   : read clock, rising edge.
//   rrst_n : asynchronous active-low reset.
//   bus    : slave side of rptr_status_if. It carries:
//            inputs  rq2_wptr, rinc, ae_wr, ae_thresh, uf_clr;
//            outputs rempty, ralmost_empty, rlevel, raddr, rptr, runderflow.
// The binary read pointer has one extra wrap bit. That is why
// wbin_s - rbinnext (mod 2**(ADDRSIZE+1)) gives the true level 0..2**ADDRSIZE.
module rptr_status
  import async_fifo_pkg::*;
#(
  parameter int ADDRSIZE = 4,
  parameter int AE_RESET = 1
) (
  input logic          rclk,
  input logic          rrst_n,
  rptr_status_if.slave bus
);
  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbinnext;
  logic [PW-1:0] rgraynext;
  logic [PW-1:0] wbin_s;
  logic [PW-1:0] level_next;
  logic [PW-1:0] thr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] rlevel;
  logic          rempty;
  logic          ralmost_empty;
  logic          runderflow;
  logic          rd_ok;
  logic          underflow_now;

  gray2bin #(.WIDTH(PW)) u_wptr_g2b (
    .gray (bus.rq2_wptr),
    .bin  (wbin_s)
  );

  always_comb begin
    // A read is accepted only against the registered empty flag.
    // A read against an empty FIFO is an underflow instead.
    rd_ok         = bus.rinc & ~rempty;
    underflow_now = bus.rinc & rempty;
    rbinnext      = rbin + PW'(rd_ok);
    rgraynext     = PW'(bin2gray(ptr_word_t'(rbinnext), PW));
    // Uses the post-read pointer, so a same-edge read and write both land.
    level_next    = wbin_s - rbinnext;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
      runderflow    <= 1'b0;
      thr           <= PW'(AE_RESET);
    end else begin
      rbin          <= rbinnext;
      rptr          <= rgraynext;
      rempty        <= (rgraynext == bus.rq2_wptr);
      rlevel        <= level_next;
      // Compares against the threshold held before this edge.
      // A value loaded on this edge takes effect from the next one.
      ralmost_empty <= (level_next <= thr);
      if (bus.ae_wr) begin
        thr <= bus.ae_thresh;
      end
      // If an underflow and a clear arrive on the same edge, the set wins.
      runderflow    <= underflow_now | (runderflow & ~bus.uf_clr);
    end
  end

  assign bus.raddr         = rbin[ADDRSIZE-1:0];
  assign bus.rptr          = rptr;
  assign bus.rempty        = rempty;
  assign bus.ralmost_empty = ralmost_empty;
  assign bus.rlevel        = rlevel;
  assign bus.runderflow    = runderflow;
endmodule

// File: tb/tb_rptr_status.sv
// Bench for rptr_status (ADDRSIZE=4, AE_RESET=1).
// The reference model counts total writes and reads as plain integers.
// Level is their difference, and pointers are derived from the counts.
module tb_rptr_status;
  localparam int AS    = 4;
  localparam int PW    = AS + 1;
  localparam int DEPTH = 16;

  logic rclk = 1'b0;
  logic rrst_n;
  always #5 rclk = ~rclk;

  rptr_status_if #(.ADDRSIZE(AS)) bus ();

  rptr_status #(.ADDRSIZE(AS), .AE_RESET(1)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  // Reference model state
  int w_cnt;
  int r_cnt;
  int m_level;
  int m_thr;
  bit m_empty;
  bit m_ae;
  bit m_uf;

  int exp_addr[4] = '{14, 15, 0, 1};
  int room;
  int inc;

  function automatic logic [PW-1:0] gray_of(input int n);
    logic [PW-1:0] b;
    b = n[PW-1:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    w_cnt   = 0;
    r_cnt   = 0;
    m_level = 0;
    m_thr   = 1;
    m_empty = 1'b1;
    m_ae    = 1'b1;
    m_uf    = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    check_val({tag, ".rempty"},        int'(bus.rempty),        int'(m_empty));
    check_val({tag, ".ralmost_empty"}, int'(bus.ralmost_empty), int'(m_ae));
    check_val({tag, ".rlevel"},        int'(bus.rlevel),        m_level);
    check_val({tag, ".raddr"},         int'(bus.raddr),         r_cnt % DEPTH);
    check_val({tag, ".rptr"},          int'(bus.rptr),          int'(gray_of(r_cnt)));
    check_val({tag, ".runderflow"},    int'(bus.runderflow),    int'(m_uf));
  endtask

  task automatic drive_wptr();
    bus.rq2_wptr = gray_of(w_cnt);
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then compare every output 1 time unit later.
  task automatic tick(input string tag);
    bit acc;
    @(posedge rclk);
    acc  = bus.rinc && !m_empty;
    m_uf = (bus.rinc && m_empty) || (m_uf && !bus.uf_clr);
    r_cnt += int'(acc);
    m_level = w_cnt - r_cnt;
    m_empty = (m_level == 0);
    m_ae    = (m_level <= m_thr);
    if (bus.ae_wr) m_thr = int'(bus.ae_thresh);
    #1;
    txn++;
    $display("txn %0d %s rinc=%0b writes=%0d reads=%0d level=%0d",
             txn, tag, bus.rinc, w_cnt, r_cnt, m_level);
    compare_all(tag);
  endtask

  initial begin
    rrst_n        = 1'b1;
    bus.rq2_wptr  = '0;
    bus.rinc      = 1'b0;
    bus.ae_wr     = 1'b0;
    bus.ae_thresh = '0;
    bus.uf_clr    = 1'b0;
    model_reset();
    #2 rrst_n = 1'b0;
    #1 compare_all("reset");
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;

    // Three words become visible.
    w_cnt = 3;
    drive_wptr();
    tick("r030");
    check_val("r030.rempty", int'(bus.rempty), 0);
    check_val("r030.rlevel", int'(bus.rlevel), 3);
    check_val("r030.ae",     int'(bus.ralmost_empty), 0);

    // Drain them.
    bus.rinc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_val("r031.raddr_pre", int'(bus.raddr), i);
      tick("r031");
      check_val("r031.rlevel", int'(bus.rlevel), 2 - i);
      check_val("r031.ae", int'(bus.ralmost_empty), ((2 - i) <= 1) ? 1 : 0);
    end
    check_val("r031.rempty", int'(bus.rempty), 1);
    check_val("r031.raddr",  int'(bus.raddr), 3);

    // Underflow: the pointer holds and the flag is sticky.
    tick("r032_uf1");
    check_val("r032.uf1",  int'(bus.runderflow), 1);
    tick("r032_uf2");
    check_val("r032.rptr", int'(bus.rptr), int'(gray_of(3)));
    bus.rinc   = 1'b0;
    bus.uf_clr = 1'b1;
    tick("r032_clr");
    check_val("r032.clr", int'(bus.runderflow), 0);
    bus.rinc = 1'b1;
    tick("uf_set_wins");
    check_val("uf_set_wins", int'(bus.runderflow), 1);
    bus.rinc = 1'b0;
    tick("uf_clear");
    bus.uf_clr = 1'b0;

    // Walk the read pointer to 30, then straddle the wrap.
    w_cnt = 19;
    drive_wptr();
    bus.rinc = 1'b1;
    for (int k = 0; k < 40 && r_cnt < 19; k++) tick("fill1");
    w_cnt = 30;
    drive_wptr();
    for (int k = 0; k < 40 && r_cnt < 30; k++) tick("fill2");
    bus.rinc = 1'b0;
    tick("settle");
    check_val("r033.raddr30", int'(bus.raddr), 14);
    w_cnt = 34;
    drive_wptr();
    tick("r033_lvl");
    check_val("r033.rlevel", int'(bus.rlevel), 4);
    bus.rinc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val("r033.raddr", int'(bus.raddr), exp_addr[i]);
      tick("r033_rd");
    end
    bus.rinc = 1'b0;
    check_val("r033.rptr",   int'(bus.rptr), 3);
    check_val("r033.rempty", int'(bus.rempty), 1);

    // Reset asserted between edges while reads are in flight.
    w_cnt = r_cnt + 5;
    drive_wptr();
    bus.rinc = 1'b1;
    tick("pre_rst");
    tick("pre_rst");
    #3 rrst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    drive_wptr();
    @(negedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
    tick("post_rst");
    check_val("post_rst.rptr", int'(bus.rptr), 0);

    // A full FIFO, then the threshold raised to 15.
    bus.rinc   = 1'b0;
    bus.uf_clr = 1'b1;
    tick("clr");
    bus.uf_clr = 1'b0;
    w_cnt = 16;
    drive_wptr();
    tick("r034_full");
    check_val("r034.rlevel", int'(bus.rlevel), 16);
    bus.ae_wr     = 1'b1;
    bus.ae_thresh = 5'd15;
    tick("r034_thr");
    bus.ae_wr = 1'b0;
    bus.rinc  = 1'b1;
    tick("r034_rd");
    bus.rinc = 1'b0;
    check_val("r034.ae",     int'(bus.ralmost_empty), 1);
    check_val("r034.rlevel", int'(bus.rlevel), 15);

    // Random traffic, with the write count kept within DEPTH of the reads.
    for (int k = 0; k < 400; k++) begin
      room = r_cnt + DEPTH - w_cnt;
      inc  = (k < 200) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
      if (inc > room) inc = room;
      w_cnt += inc;
      drive_wptr();
      bus.rinc      = ($urandom_range(0, 99) < 60);
      bus.ae_wr     = ($urandom_range(0, 19) == 0);
      bus.ae_thresh = PW'($urandom_range(0, 16));
      bus.uf_clr    = ($urandom_range(0, 7) == 0);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
